intr_ctrl: RTL and testbench
============================

# intr_ctrl

Multi-source interrupt controller that sequences interrupt entry and exit for the OTTER MCU. It sits between the external interrupt lines, the pipeline control logic and the CSR block. It latches rising edges per source into pending bits and masks them per source and by mstatus.MIE. It selects the highest-priority source, performs an interrupt-taken handshake with the pipeline at an instruction boundary, and then blocks further entries until the handler executes mret.

## Interface
Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16)
- ID_W, $clog2(NUM_SRC), width of INT_ID

Ports:
- CLK  in  1  system clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- IRQ  in  NUM_SRC  level interrupt lines, already synchronous to CLK
- SRC_EN  in  NUM_SRC  per-source enable mask (1 = enabled)
- CSR_MSTATUS_MIE  in  1  global interrupt enable from CSR
- MRET_EXEC  in  1  one-cycle pulse, mret executing
- PIPE_READY  in  1  pipeline is at an instruction boundary and can redirect PC this cycle
- PEND_CLR  in  NUM_SRC  software write-1-to-clear of pending bits
- INT_TAKEN  out  1  one-cycle pulse to CSR (saves MEPC, clears MIE) and PC mux (selects MTVEC)
- INT_ID  out  ID_W  index of the last source taken
- PENDING  out  NUM_SRC  pending bits
- IN_SERVICE  out  1  handler active (taken, mret not yet seen)

## Operation
- Edge detect: the block keeps an internal register irq_q of IRQ. rise[i] = IRQ[i] & ~irq_q[i]. irq_q resets to all-ones, so a line held high through reset does not register as an edge.
- Pending update, per bit, evaluated in this order each cycle:
  - clear if PEND_CLR[i];
  - clear if the bit is taken this cycle;
  - then set if rise[i].
  - A rise in the same cycle as a clear or take leaves the bit set.
- Eligible: elig = PENDING & SRC_EN. Winner is the lowest set index of elig; index 0 has highest priority.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if elig != 0 and CSR_MSTATUS_MIE, go to REQ; otherwise stay.
  - REQ:
    - If CSR_MSTATUS_MIE = 0 or elig = 0, return to IDLE with no take.
    - Otherwise, if PIPE_READY: assert INT_TAKEN, clear PENDING[winner], load INT_ID <= winner, go to SERVICE.
    - Otherwise stay. The winner is recomputed every cycle, so a higher-priority arrival preempts the selection.
  - SERVICE: IN_SERVICE = 1. On MRET_EXEC go to IDLE. New edges still set pending bits but cannot be taken.
- MRET_EXEC in IDLE or REQ is ignored.
- INT_TAKEN is combinational: (state == REQ) & PIPE_READY & CSR_MSTATUS_MIE & (elig != 0). It is never asserted for two consecutive cycles.
- IN_SERVICE = (state == SERVICE), decoded from the registered state.
- Reset: state = IDLE, PENDING = 0, INT_ID = 0, irq_q = all-ones. Resulting outputs: INT_TAKEN = 0, IN_SERVICE = 0. RST mid-REQ or mid-SERVICE abandons the operation with no INT_TAKEN, and any pending bits are lost.

## Timing
- Edge-to-PENDING: the IRQ rise is sampled at edge N, and PENDING is visible after edge N.
- Minimum latency from IRQ rise to INT_TAKEN is 2 cycles, with MIE = 1 and PIPE_READY = 1 throughout:
  - cycle 1: PENDING set;
  - cycle 2: state REQ, INT_TAKEN high during cycle 2 (combinational).
- INT_TAKEN is valid in the same cycle as PIPE_READY; the pipeline and CSR sample it at the next posedge.
- INT_ID and IN_SERVICE update at the posedge that ends the INT_TAKEN cycle.
- SERVICE to IDLE takes one edge after MRET_EXEC. The earliest next INT_TAKEN is 2 cycles after the MRET_EXEC cycle.
- PEND_CLR takes effect at the next posedge; clear-then-set ordering resolves a simultaneous rise.

## Test plan
- Reset/idle:
  - Stimulus: assert RST with IRQ = 4'b1111, release, hold IRQ high, MIE = 1, SRC_EN = all.
  - Required: PENDING = 0, no INT_TAKEN for 10 cycles.
- Single take:
  - Stimulus: MIE = 1, SRC_EN = 4'b1111, PIPE_READY = 1, rise IRQ[2].
  - Required: INT_TAKEN pulses exactly 1 cycle, 2 cycles after the rise. INT_ID = 2 and IN_SERVICE = 1 next cycle. PENDING[2] = 0.
- Priority and preemption in REQ:
  - Stimulus: PIPE_READY = 0, rise IRQ[3]; 2 cycles later rise IRQ[1]; then PIPE_READY = 1.
  - Required: first take has INT_ID = 1, and PENDING = 4'b1000 remains.
  - Then MRET_EXEC: required second take with INT_ID = 3.
- Masking:
  - Stimulus: SRC_EN = 4'b1110, rise IRQ[0].
  - Required: PENDING[0] = 1, no take.
  - Then MIE = 0 and SRC_EN = all: required no take. Then MIE = 1: required take with INT_ID = 0.
- Nesting blocked:
  - Stimulus: rise IRQ[0] while in SERVICE.
  - Required: PENDING[0] = 1, no INT_TAKEN until MRET_EXEC. INT_TAKEN follows 2 cycles after MRET_EXEC.
- Simultaneous events:
  - Stimulus 1: PEND_CLR[1] and rise IRQ[1] in the same cycle. Required: PENDING[1] = 1.
  - Stimulus 2: RST asserted while in REQ. Required: IDLE, PENDING = 0, no INT_TAKEN.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt entry/exit sequencer: edge-latched pending bits, fixed priority (index 0 highest).
// INT_TAKEN is combinational in REQ when PIPE_READY; further entries are blocked until MRET_EXEC.
module intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic [NUM_SRC-1:0] SRC_EN,
  input  logic               CSR_MSTATUS_MIE,
  input  logic               MRET_EXEC,
  input  logic               PIPE_READY,
  input  logic [NUM_SRC-1:0] PEND_CLR,
  output logic               INT_TAKEN,
  output logic [ID_W-1:0]    INT_ID,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               IN_SERVICE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [ID_W-1:0]    winner;
  logic               any_elig;
  logic               take;

  assign rise     = IRQ & ~irq_q;
  assign elig     = PENDING & SRC_EN;
  assign any_elig = |elig;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_elig && CSR_MSTATUS_MIE) state_nxt = REQ;
      end
      REQ: begin
        if (!CSR_MSTATUS_MIE || !any_elig) state_nxt = IDLE;
        else if (PIPE_READY)               state_nxt = SERVICE;
      end
      SERVICE: begin
        if (MRET_EXEC) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the take so an abandoned REQ never redirects the pipeline.
  always_comb begin
    take       = (state == REQ) && PIPE_READY && CSR_MSTATUS_MIE && any_elig && !RST;
    INT_TAKEN  = take;
    IN_SERVICE = (state == SERVICE);
  end

  // Clear (software, then take) before set, so a coincident rise wins.
  always_comb begin
    pend_nxt = PENDING;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (PEND_CLR[i])                     pend_nxt[i] = 1'b0;
      if (take && (winner == ID_W'(i)))    pend_nxt[i] = 1'b0;
      if (rise[i])                         pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_q   <= '1;
      PENDING <= '0;
      INT_ID  <= '0;
    end else begin
      irq_q   <= IRQ;
      PENDING <= pend_nxt;
      if (take) INT_ID <= winner;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized and directed bench for intr_ctrl against a per-cycle reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic [3:0] src_en;
  logic       mie;
  logic       mret;
  logic       ready;
  logic [3:0] pend_clr;
  logic       int_taken;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic       in_service;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending vector, phase (0 idle, 1 requesting, 2 handler), last id.
  logic [3:0] m_pend;
  logic [3:0] m_irq_q;
  int         m_phase;
  int         m_id;
  logic       seen_take;

  intr_ctrl #(.NUM_SRC(4)) dut (
    .CLK             (clk),
    .RST             (rst),
    .IRQ             (irq),
    .SRC_EN          (src_en),
    .CSR_MSTATUS_MIE (mie),
    .MRET_EXEC       (mret),
    .PIPE_READY      (ready),
    .PEND_CLR        (pend_clr),
    .INT_TAKEN       (int_taken),
    .INT_ID          (int_id),
    .PENDING         (pending),
    .IN_SERVICE      (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    logic [3:0] iso;
    iso = v & (~v + 4'd1);
    for (int k = 0; k < 4; k++) if (iso == (4'd1 << k)) return k;
    return 0;
  endfunction

  // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic [3:0] elig, np, rise;
    logic       exp_take;
    int         win;
    #5;
    elig     = m_pend & src_en;
    exp_take = (m_phase == 1) && mie && ready && (elig != 0) && !rst;
    win      = lowest(elig);
    chk("int_taken",  32'(int_taken),  32'(exp_take));
    chk("pending",    32'(pending),    32'(m_pend));
    chk("int_id",     32'(int_id),     32'(m_id));
    chk("in_service", 32'(in_service), 32'(m_phase == 2));
    seen_take = int_taken;
    @(posedge clk);
    if (rst) begin
      m_pend = 4'd0; m_irq_q = 4'hF; m_phase = 0; m_id = 0;
    end else begin
      rise = irq & ~m_irq_q;
      np   = m_pend & ~pend_clr;
      if (exp_take) begin
        np   = np & ~(4'd1 << win);
        m_id = win;
      end
      np = np | rise;
      case (m_phase)
        0: if (elig != 0 && mie) m_phase = 1;
        1: if (!mie || elig == 0) m_phase = 0; else if (ready) m_phase = 2;
        default: if (mret) m_phase = 0;
      endcase
      m_pend  = np;
      m_irq_q = irq;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Counts cycles until INT_TAKEN is seen, bounded by a budget.
  task automatic wait_take(input int budget, output int n);
    n = 0;
    seen_take = 1'b0;
    while (!seen_take && n < budget) begin
      n++;
      cycle();
    end
    if (!seen_take) n = -1;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; cycle(); mret = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; irq = 4'hF; src_en = 4'hF; mie = 1'b1; mret = 1'b0;
    ready = 1'b1; pend_clr = 4'd0;
    m_pend = 4'd0; m_irq_q = 4'hF; m_phase = 0; m_id = 0; seen_take = 1'b0;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;

    // Lines held high through reset must not register as edges.
    run(10);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_service", 32'(in_service), 32'd0);

    // Single take of source 2.
    irq = 4'd0; run(2);
    irq = 4'b0100; cycle();
    wait_take(10, lat);
    chk("single_latency", 32'(lat), 32'd2);
    cycle();
    chk("single_id", 32'(int_id), 32'd2);
    chk("single_svc", 32'(in_service), 32'd1);
    chk("single_pend", 32'(pending[2]), 32'd0);
    pulse_mret(); irq = 4'd0; run(3);

    // Higher-priority arrival while waiting for the pipeline preempts.
    ready = 1'b0;
    irq = 4'b1000; run(2);
    irq = 4'b1010; run(3);
    ready = 1'b1;
    wait_take(10, lat);
    cycle();
    chk("prio_id", 32'(int_id), 32'd1);
    chk("prio_pend", 32'(pending), 32'b1000);
    pulse_mret();
    wait_take(10, lat);
    cycle();
    chk("prio_second_id", 32'(int_id), 32'd3);
    pulse_mret(); irq = 4'd0; run(3);

    // Source mask, then global mask.
    src_en = 4'b1110;
    irq = 4'b0001; run(6);
    chk("mask_pend", 32'(pending[0]), 32'd1);
    chk("mask_svc", 32'(in_service), 32'd0);
    mie = 1'b0; src_en = 4'hF; run(6);
    chk("mie_svc", 32'(in_service), 32'd0);
    mie = 1'b1;
    wait_take(10, lat);
    cycle();
    chk("unmask_id", 32'(int_id), 32'd0);
    pulse_mret(); irq = 4'd0; run(3);

    // No nesting while in service.
    irq = 4'b0100; cycle();
    wait_take(10, lat); cycle();
    irq = 4'b0101; run(6);
    chk("nest_pend", 32'(pending[0]), 32'd1);
    chk("nest_svc", 32'(in_service), 32'd1);
    pulse_mret();
    wait_take(10, lat);
    chk("mret_latency", 32'(lat), 32'd2);
    cycle(); pulse_mret(); irq = 4'd0; run(3);

    // Coincident software clear and rise: the rise wins.
    src_en = 4'd0;
    irq = 4'b0010; run(2);
    irq = 4'd0; cycle();
    irq = 4'b0010; pend_clr = 4'b0010; cycle();
    pend_clr = 4'd0; cycle();
    chk("clr_rise_pend", 32'(pending[1]), 32'd1);
    pend_clr = 4'b0010; cycle();
    pend_clr = 4'd0; cycle();
    chk("clr_only_pend", 32'(pending[1]), 32'd0);

    // Reset while requesting abandons the take.
    src_en = 4'hF; ready = 1'b0; irq = 4'b1000; run(4);
    rst = 1'b1; ready = 1'b1; cycle();
    rst = 1'b0; run(4);
    chk("rst_req_pend", 32'(pending), 32'd0);
    chk("rst_req_svc", 32'(in_service), 32'd0);
    irq = 4'd0; run(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ 4'($urandom);
      src_en   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      mie      = ($urandom_range(0, 9) != 0);
      ready    = $urandom_range(0, 1) == 1;
      mret     = ($urandom_range(0, 7) == 0);
      pend_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
      rst      = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
